mem_access_ctrl: RTL and testbench

//  Multi-cycle controller for data-memory ops (lb/lh/lw/lbu/lhu/sb/sh/sw) flagged by the decoder (REG_SRC_RAM / store ops).

---
 rtl/mem_access_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// Multi-cycle data-memory access controller: one load/store in flight on a req/ack RAM port,
// with pipeline stall, byte-lane steering, load extension and misalign/timeout exceptions.
module mem_access_ctrl #(
    parameter int TIMEOUT = 16
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    input  logic [5:0]  i_op,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic        o_stall,
    output logic        o_done,
    output logic        o_excp,
    output logic [31:0] o_rdata_out,
    output logic        o_mem_req,
    output logic        o_mem_we,
    output logic [31:0] o_mem_addr,
    output logic [3:0]  o_mem_be,
    output logic [31:0] o_mem_wdata,
    input  logic        i_mem_ack,
    input  logic [31:0] i_mem_rdata
);

    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2B;

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [5:0]    r_op;
    logic [1:0]    r_lo;
    logic          r_done;
    logic          r_excp;
    logic [31:0]   r_rdata_out;
    logic          r_mem_req;
    logic          r_mem_we;
    logic [31:0]   r_mem_addr;
    logic [3:0]    r_mem_be;
    logic [31:0]   r_mem_wdata;

    logic          w_is_mem;
    logic          w_is_store;
    logic          w_misal;
    logic [3:0]    w_be;
    logic [31:0]   w_wdata;
    logic [7:0]    w_byte;
    logic [15:0]   w_half;
    logic [31:0]   w_load;

    // Decode of the incoming request (only meaningful in IDLE)
    always_comb begin
        w_is_mem   = 1'b0;
        w_is_store = 1'b0;
        w_misal    = 1'b0;
        w_be       = 4'b0000;
        w_wdata    = i_wdata;
        case (i_op)
            OP_LB, OP_LBU, OP_SB: begin
                w_is_mem = 1'b1;
                w_be     = 4'b0001 << i_addr[1:0];
                w_wdata  = {4{i_wdata[7:0]}};
            end
            OP_LH, OP_LHU, OP_SH: begin
                w_is_mem = 1'b1;
                w_misal  = i_addr[0];
                w_be     = i_addr[1] ? 4'b1100 : 4'b0011;
                w_wdata  = {2{i_wdata[15:0]}};
            end
            OP_LW, OP_SW: begin
                w_is_mem = 1'b1;
                w_misal  = |i_addr[1:0];
                w_be     = 4'b1111;
            end
            default: ;
        endcase
        w_is_store = (i_op == OP_SB) || (i_op == OP_SH) || (i_op == OP_SW);
    end

    // Lane select and extension of the returned word, using the latched op/offset
    always_comb begin
        w_byte = 8'h00;
        case (r_lo)
            2'd0: w_byte = i_mem_rdata[7:0];
            2'd1: w_byte = i_mem_rdata[15:8];
            2'd2: w_byte = i_mem_rdata[23:16];
            2'd3: w_byte = i_mem_rdata[31:24];
            default: ;
        endcase
        w_half = r_lo[1] ? i_mem_rdata[31:16] : i_mem_rdata[15:0];
        w_load = i_mem_rdata;
        case (r_op)
            OP_LB:   w_load = {{24{w_byte[7]}}, w_byte};
            OP_LBU:  w_load = {24'h0, w_byte};
            OP_LH:   w_load = {{16{w_half[15]}}, w_half};
            OP_LHU:  w_load = {16'h0, w_half};
            default: w_load = i_mem_rdata;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_op        <= '0;
            r_lo        <= '0;
            r_done      <= 1'b0;
            r_excp      <= 1'b0;
            r_rdata_out <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_be    <= '0;
            r_mem_wdata <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_start && w_is_mem) begin
                        if (w_misal) begin
                            r_state <= RESP;
                            r_done  <= 1'b1;
                            r_excp  <= 1'b1;
                        end else begin
                            r_state     <= BUSY;
                            r_cnt       <= '0;
                            r_op        <= i_op;
                            r_lo        <= i_addr[1:0];
                            r_mem_req   <= 1'b1;
                            r_mem_we    <= w_is_store;
                            r_mem_addr  <= {i_addr[31:2], 2'b00};
                            r_mem_be    <= w_be;
                            r_mem_wdata <= w_wdata;
                        end
                    end
                end
                BUSY: begin
                    // An ack landing in the final counted cycle still wins over the timeout
                    if (i_mem_ack) begin
                        r_state   <= RESP;
                        r_mem_req <= 1'b0;
                        r_done    <= 1'b1;
                        r_excp    <= 1'b0;
                        if (!r_mem_we) r_rdata_out <= w_load;
                    end else if (r_cnt == CNT_MAX) begin
                        r_state   <= RESP;
                        r_mem_req <= 1'b0;
                        r_done    <= 1'b1;
                        r_excp    <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                RESP: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                    r_excp  <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Low in RESP so the pipeline advances in the done cycle
    assign o_stall     = ((r_state == IDLE) && i_start && w_is_mem) || (r_state == BUSY);
    assign o_done      = r_done;
    assign o_excp      = r_excp;
    assign o_rdata_out = r_rdata_out;
    assign o_mem_req   = r_mem_req;
    assign o_mem_we    = r_mem_we;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_be    = r_mem_be;
    assign o_mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl (TIMEOUT=4): vector table of single accesses
// plus hand sequences for reset, ignored starts and stray acks.
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [5:0]  op;
    logic [31:0] addr, wdata;
    logic        stall, done, excp;
    logic [31:0] rdata_out;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int total = 0;
    int bad   = 0;

    mem_access_ctrl #(.TIMEOUT(4)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_op(op), .i_addr(addr),
        .i_wdata(wdata), .o_stall(stall), .o_done(done), .o_excp(excp),
        .o_rdata_out(rdata_out), .o_mem_req(mem_req), .o_mem_we(mem_we),
        .o_mem_addr(mem_addr), .o_mem_be(mem_be), .o_mem_wdata(mem_wdata),
        .i_mem_ack(mem_ack), .i_mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    typedef struct {
        logic [5:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          d;      // ack in the d-th request cycle; 0 = never
        logic [3:0]  be;
        logic        we;
        logic [31:0] mwd;
        logic [31:0] rd;     // rdata_out after the access
        logic        excp;
        int          nreq;   // expected number of mem_req cycles
    } vec_t;

    vec_t tv[16];

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", n, act, exp);
        end
    endtask

    task automatic run(input vec_t v, input string tag);
        int nreq = 0;
        int done_c = 0;
        logic [31:0] a0 = '0, w0 = '0;
        logic [3:0]  b0 = '0;
        logic        we0 = 1'b0;
        bit          unstable = 1'b0;
        logic        got_excp = 1'b0;
        @(negedge clk);
        start = 1'b1; op = v.op; addr = v.addr; wdata = v.wdata;
        #1 chk({tag, " stall@0"}, 32'(stall), 32'd1);
        for (int c = 1; c <= 40 && done_c == 0; c++) begin
            @(negedge clk);
            start = 1'b0;
            mem_ack = 1'b0;
            if (mem_req) begin
                nreq++;
                if (nreq == 1) begin
                    a0 = mem_addr; b0 = mem_be; we0 = mem_we; w0 = mem_wdata;
                end else if (a0 !== mem_addr || b0 !== mem_be || we0 !== mem_we || w0 !== mem_wdata) begin
                    unstable = 1'b1;
                end
                if (nreq == v.d) begin
                    mem_ack = 1'b1;
                    mem_rdata = v.rdata;
                end
            end
            if (done) begin
                done_c = c;
                got_excp = excp;
                #1 chk({tag, " stall@done"}, 32'(stall), 32'd0);
            end
        end
        mem_ack = 1'b0;
        chk({tag, " done_cycle"}, 32'(done_c), 32'(v.nreq + 1));
        chk({tag, " excp"}, 32'(got_excp), 32'(v.excp));
        chk({tag, " req_cycles"}, 32'(nreq), 32'(v.nreq));
        chk({tag, " rdata_out"}, rdata_out, v.rd);
        if (v.nreq > 0) begin
            chk({tag, " mem_addr"}, a0, {v.addr[31:2], 2'b00});
            chk({tag, " mem_be"}, 32'(b0), 32'(v.be));
            chk({tag, " mem_we"}, 32'(we0), 32'(v.we));
            chk({tag, " stable"}, 32'(unstable), 32'd0);
            if (v.we) chk({tag, " mem_wdata"}, w0, v.mwd);
        end
    endtask

    initial begin
        bit seen;
        //         op     addr      wdata         rdata         d  be      we    mwd           rd            ex    nreq
        tv[0]  = '{6'h23, 32'h100, 32'h0,        32'hDEADBEEF, 1, 4'hF, 1'b0, 32'h0,        32'hDEADBEEF, 1'b0, 1};
        tv[1]  = '{6'h20, 32'h103, 32'h0,        32'h80FF0000, 1, 4'h8, 1'b0, 32'h0,        32'hFFFFFF80, 1'b0, 1};
        tv[2]  = '{6'h24, 32'h103, 32'h0,        32'h80FF0000, 1, 4'h8, 1'b0, 32'h0,        32'h00000080, 1'b0, 1};
        tv[3]  = '{6'h25, 32'h102, 32'h0,        32'h80FF0000, 1, 4'hC, 1'b0, 32'h0,        32'h000080FF, 1'b0, 1};
        tv[4]  = '{6'h21, 32'h102, 32'h0,        32'h80FF0000, 2, 4'hC, 1'b0, 32'h0,        32'hFFFF80FF, 1'b0, 2};
        tv[5]  = '{6'h20, 32'h101, 32'h0,        32'h12345678, 1, 4'h2, 1'b0, 32'h0,        32'h00000056, 1'b0, 1};
        tv[6]  = '{6'h29, 32'h202, 32'h1234ABCD, 32'h0,        3, 4'hC, 1'b1, 32'hABCDABCD, 32'h00000056, 1'b0, 3};
        tv[7]  = '{6'h28, 32'h201, 32'h000000A5, 32'h0,        2, 4'h2, 1'b1, 32'hA5A5A5A5, 32'h00000056, 1'b0, 2};
        tv[8]  = '{6'h23, 32'h101, 32'h0,        32'h0,        0, 4'h0, 1'b0, 32'h0,        32'h00000056, 1'b1, 0};
        tv[9]  = '{6'h2B, 32'h300, 32'hCAFEF00D, 32'h0,        0, 4'hF, 1'b1, 32'hCAFEF00D, 32'h00000056, 1'b1, 4};
        tv[10] = '{6'h2B, 32'h304, 32'h11223344, 32'h0,        4, 4'hF, 1'b1, 32'h11223344, 32'h00000056, 1'b0, 4};
        tv[11] = '{6'h21, 32'h103, 32'h0,        32'h0,        0, 4'h0, 1'b0, 32'h0,        32'h00000056, 1'b1, 0};
        tv[12] = '{6'h25, 32'h100, 32'h0,        32'hFFFF8001, 1, 4'h3, 1'b0, 32'h0,        32'h00008001, 1'b0, 1};
        tv[13] = '{6'h20, 32'h102, 32'h0,        32'h00800000, 1, 4'h4, 1'b0, 32'h0,        32'hFFFFFF80, 1'b0, 1};
        tv[14] = '{6'h2B, 32'h302, 32'h0,        32'h0,        0, 4'h0, 1'b0, 32'h0,        32'hFFFFFF80, 1'b1, 0};
        tv[15] = '{6'h24, 32'h100, 32'h0,        32'h000000FE, 1, 4'h1, 1'b0, 32'h0,        32'h000000FE, 1'b0, 1};

        rst_n = 1'b0; start = 1'b0; op = '0; addr = '0; wdata = '0;
        mem_ack = 1'b0; mem_rdata = '0;
        repeat (2) @(negedge clk);
        chk("reset mem_req", 32'(mem_req), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset excp", 32'(excp), 32'd0);
        chk("reset rdata_out", rdata_out, 32'd0);
        chk("reset stall", 32'(stall), 32'd0);
        chk("reset mem_be", 32'(mem_be), 32'd0);
        chk("reset mem_addr", mem_addr, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) run(tv[i], $sformatf("v%0d", i));

        // Non-memory op with start: no stall, no request, no done
        @(negedge clk);
        start = 1'b1; op = 6'h08; addr = 32'h100;
        #1 chk("nonmem stall", 32'(stall), 32'd0);
        seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            start = 1'b0;
            if (done || mem_req) seen = 1'b1;
        end
        chk("nonmem no activity", 32'(seen), 32'd0);

        // start asserted during the done cycle is ignored
        @(negedge clk);
        start = 1'b1; op = 6'h23; addr = 32'h400;
        @(negedge clk);
        start = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h5555AAAA;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("resp done", 32'(done), 32'd1);
        start = 1'b1;
        #1 chk("resp stall w/ start", 32'(stall), 32'd0);
        @(negedge clk);
        start = 1'b0;
        chk("resp start ignored req", 32'(mem_req), 32'd0);
        chk("resp done one cycle", 32'(done), 32'd0);
        chk("resp rdata_out", rdata_out, 32'h5555AAAA);

        // Reset in the middle of an access, then a stray ack in IDLE
        @(negedge clk);
        start = 1'b1; op = 6'h23; addr = 32'h500;
        @(negedge clk);
        start = 1'b0;
        chk("midrst req@1", 32'(mem_req), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst req@3", 32'(mem_req), 32'd0);
        chk("midrst stall@3", 32'(stall), 32'd0);
        chk("midrst done@3", 32'(done), 32'd0);
        chk("midrst rdata_out", rdata_out, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        mem_ack = 1'b1; mem_rdata = 32'hFFFFFFFF;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("stray ack done", 32'(done), 32'd0);
        chk("stray ack req", 32'(mem_req), 32'd0);
        chk("stray ack rdata_out", rdata_out, 32'd0);
        run('{6'h23, 32'h504, 32'h0, 32'h13579BDF, 2, 4'hF, 1'b0, 32'h0, 32'h13579BDF, 1'b0, 2}, "post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
